// File: rtl/matrix_layer_scheduler_pkg.sv
// Shared types and constants for the matrix layer scheduler.
package matrix_scheduler_pkg;

    localparam int SIZE      = 3;
    localparam int DATA_SIZE = 16;
    localparam int MAX_LAYER = 5;
    localparam int ROW_W     = SIZE * DATA_SIZE;

    localparam logic [31:0] SIZE_U      = 32'(SIZE);
    localparam logic [31:0] MAX_LAYER_U = 32'(MAX_LAYER);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } sched_state_e;

    // Next index with wrap to zero at limit; a zero result means the index wrapped.
    function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] limit);
        return (idx == limit - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/matrix_layer_scheduler_if.sv
// Loader, storage and row-stream signals of the scheduler grouped as one bus.
interface matrix_layer_scheduler_if;
    import matrix_scheduler_pkg::*;

    logic             load_valid;
    logic             load_ready;
    logic [ROW_W-1:0] load_data;
    logic [31:0]      load_layer_index;
    logic [31:0]      load_row_index;

    logic [ROW_W-1:0] storage_write_data;
    logic [31:0]      storage_write_layer_index;
    logic [31:0]      storage_write_row_index;
    logic             storage_is_write;
    logic [31:0]      storage_read_layer_index;
    logic [31:0]      storage_read_row_index;
    logic             storage_is_read;
    logic [ROW_W-1:0] storage_read_data;

    logic             row_valid;
    logic             row_ready;
    logic [ROW_W-1:0] row_data;
    logic [31:0]      row_layer;
    logic [31:0]      row_row;
    logic             row_last;
    logic             row_final;

    modport master (
        input  load_valid, load_data, load_layer_index, load_row_index,
        output load_ready,
        output storage_write_data, storage_write_layer_index, storage_write_row_index,
        output storage_is_write, storage_read_layer_index, storage_read_row_index,
        output storage_is_read,
        input  storage_read_data,
        output row_valid, row_data, row_layer, row_row, row_last, row_final,
        input  row_ready
    );

    modport slave (
        output load_valid, load_data, load_layer_index, load_row_index,
        input  load_ready,
        input  storage_write_data, storage_write_layer_index, storage_write_row_index,
        input  storage_is_write, storage_read_layer_index, storage_read_row_index,
        input  storage_is_read,
        output storage_read_data,
        input  row_valid, row_data, row_layer, row_row, row_last, row_final,
        output row_ready
    );

endinterface

// File: rtl/matrix_layer_scheduler_row_output_register.sv
// One-entry valid/ready holding register for a row beat and its tags.
module row_output_register
    import matrix_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [ROW_W-1:0] in_data,
    input  logic [31:0]      in_layer,
    input  logic [31:0]      in_row,
    input  logic             in_last,
    input  logic             in_final,
    input  logic             ready,
    output logic             capture_enable,
    output logic             valid,
    output logic [ROW_W-1:0] data,
    output logic [31:0]      layer,
    output logic [31:0]      row,
    output logic             last,
    output logic             final_row
);

    logic             valid_q, valid_d;
    logic [ROW_W-1:0] data_q, data_d;
    logic [31:0]      layer_q, layer_d, row_q, row_d;
    logic             last_q, last_d, final_q, final_d;

    assign capture_enable = !valid_q || ready;

    // Refill when the slot is free or draining; otherwise hold contents for the consumer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        layer_d = layer_q;
        row_d   = row_q;
        last_d  = last_q;
        final_d = final_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load && capture_enable) begin
            valid_d = 1'b1;
            data_d  = in_data;
            layer_d = in_layer;
            row_d   = in_row;
            last_d  = in_last;
            final_d = in_final;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            layer_q <= '0;
            row_q   <= '0;
            last_q  <= 1'b0;
            final_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            layer_q <= layer_d;
            row_q   <= row_d;
            last_q  <= last_d;
            final_q <= final_d;
        end
    end

    assign valid     = valid_q;
    assign data      = data_q;
    assign layer     = layer_q;
    assign row       = row_q;
    assign last      = last_q;
    assign final_row = final_q;

endmodule

// File: rtl/matrix_layer_scheduler.sv
// Streams stored weight rows layer by layer and arbitrates the storage write port.
//
//   state  | meaning
//   IDLE   | loader owns the write port; waits for start
//   STREAM | reading storage and capturing one row per free output slot
//   FLUSH  | final row captured; waiting for its handshake
module matrix_layer_scheduler
    import matrix_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] layer_count,
    output logic        busy,
    output logic        done,
    output logic        config_error,
    matrix_layer_scheduler_if.master bus
);

    sched_state_e state_q, state_d;
    logic [31:0]  rd_layer_q, rd_layer_d, rd_row_q, rd_row_d, eff_q, eff_d;
    logic         armed_q, armed_d;
    logic         done_q, done_d, cfg_err_q, cfg_err_d, load_ready_q, load_ready_d;
    logic         capture, cap_en, cap_last, cap_final, load_ok, load_in_range;

    // Storage needs one settled cycle at row 0 before the first capture, hence armed.
    assign cap_last      = (rd_row_q == SIZE_U - 32'd1);
    assign cap_final     = cap_last && (rd_layer_q == eff_q - 32'd1);
    assign load_ok       = bus.load_valid && load_ready_q;
    assign load_in_range = (bus.load_layer_index < MAX_LAYER_U) && (bus.load_row_index < SIZE_U);

    assign bus.storage_write_data        = bus.load_data;
    assign bus.storage_write_layer_index = bus.load_layer_index;
    assign bus.storage_write_row_index   = bus.load_row_index;
    assign bus.storage_is_write          = load_ok && load_in_range;
    assign bus.storage_read_layer_index  = rd_layer_q;
    assign bus.storage_read_row_index    = rd_row_q;
    assign bus.storage_is_read           = (state_q == STREAM);
    assign bus.load_ready                = load_ready_q;

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign config_error = cfg_err_q;

    // Next-state, read-index advance and status flag logic.
    always_comb begin
        state_d    = state_q;
        rd_layer_d = rd_layer_q;
        rd_row_d   = rd_row_q;
        eff_d      = eff_q;
        armed_d    = armed_q;
        done_d     = 1'b0;
        cfg_err_d  = cfg_err_q;
        capture    = 1'b0;
        if (abort) begin
            state_d    = IDLE;
            rd_layer_d = '0;
            rd_row_d   = '0;
            armed_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cfg_err_d = 1'b0;
                        if (layer_count == 32'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d    = STREAM;
                            rd_layer_d = '0;
                            rd_row_d   = '0;
                            armed_d    = 1'b0;
                            if (layer_count > MAX_LAYER_U) begin
                                eff_d     = MAX_LAYER_U;
                                cfg_err_d = 1'b1;
                            end else begin
                                eff_d = layer_count;
                            end
                        end
                    end
                end
                STREAM: begin
                    armed_d = 1'b1;
                    if (armed_q && cap_en) begin
                        capture  = 1'b1;
                        rd_row_d = wrap_inc(rd_row_q, SIZE_U);
                        if (rd_row_d == 32'd0) begin
                            rd_layer_d = rd_layer_q + 32'd1;
                        end
                        if (cap_final) begin
                            state_d    = FLUSH;
                            rd_layer_d = '0;
                            rd_row_d   = '0;
                            armed_d    = 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.row_valid && bus.row_ready) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (load_ok && !load_in_range) begin
            cfg_err_d = 1'b1;
        end
    end

    assign load_ready_d = (state_d == IDLE);

    // Scheduler state and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rd_layer_q   <= '0;
            rd_row_q     <= '0;
            eff_q        <= '0;
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_layer_q   <= rd_layer_d;
            rd_row_q     <= rd_row_d;
            eff_q        <= eff_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            load_ready_q <= load_ready_d;
        end
    end

    row_output_register u_row_out (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (abort),
        .load           (capture),
        .in_data        (bus.storage_read_data),
        .in_layer       (rd_layer_q),
        .in_row         (rd_row_q),
        .in_last        (cap_last),
        .in_final       (cap_final),
        .ready          (bus.row_ready),
        .capture_enable (cap_en),
        .valid          (bus.row_valid),
        .data           (bus.row_data),
        .layer          (bus.row_layer),
        .row            (bus.row_row),
        .last           (bus.row_last),
        .final_row      (bus.row_final)
    );

endmodule

// File: doc/matrix_layer_scheduler.md
Name: matrix_layer_scheduler

Overview:
- Controller that owns both ports of the matrix_storage block.
- Sequences the stored weight rows out, layer by layer and row by row, into a valid/ready stream for the compute datapath.
- Shares the storage write port with a host loader; writes are accepted only while no stream is running.

Parameters:
size, 3, matrix dimension; elements per row and rows per layer
data_size, 16, bits per element
max_layer, 5, number of layers held in storage

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin streaming; sampled only in IDLE
abort  input  1  terminate the stream; return to IDLE
layer_count  input  32  number of layers to stream, from layer 0
busy  output  1  high when state is not IDLE
done  output  1  one-cycle pulse after the final row is accepted
config_error  output  1  sticky; set on a clamped layer_count or a dropped load; cleared on an accepted start
load_valid  input  1  loader write request
load_ready  output  1  loader write accepted; equals (state==IDLE)
load_data  input  data_size*size  row to write; element 0 in the MSBs
load_layer_index  input  32  target layer
load_row_index  input  32  target row
storage_write_data  output  data_size*size  to storage write_data
storage_write_layer_index  output  32  to storage
storage_write_row_index  output  32  to storage
storage_is_write  output  1  to storage
storage_read_layer_index  output  32  to storage
storage_read_row_index  output  32  to storage
storage_is_read  output  1  to storage
storage_read_data  input  data_size*size  combinational read data from storage
row_valid  output  1  stream beat valid
row_ready  input  1  downstream accept
row_data  output  data_size*size  row contents
row_layer  output  32  layer tag of the beat
row_row  output  32  row tag of the beat
row_last  output  1  beat is the last row of its layer
row_final  output  1  beat is the last row of the stream

Behaviour:
- Reset: every output low or zero; state IDLE. Asynchronous assertion, synchronous release at the clk edge.
- States and transitions:
  - IDLE -> STREAM on start when effective layer count is nonzero.
  - STREAM -> FLUSH when the final row is captured.
  - FLUSH -> IDLE on the final handshake.
- Effective layer count:
  - layer_count > max_layer: clamp to max_layer and set config_error.
  - layer_count == 0: done pulses on the next cycle; no beats; state stays IDLE.
- IDLE, loader path:
  - Write fields pass straight through to the storage write port.
  - storage_is_write = load_valid && load_ready && load_layer_index < max_layer && load_row_index < size.
  - Out-of-range loads are accepted but not written, and set config_error.
- Entering STREAM:
  - Read indices registered to layer 0, row 0.
  - storage_is_read held high for the whole of STREAM; low in every other state.
- STREAM, capture:
  - On each edge where (!row_valid || row_ready): register storage_read_data and the current indices into row_data, row_layer, row_row; set row_valid.
  - row_last = (row == size-1).
  - row_final = last row of the last layer.
  - Advance: row+1; on row wrap to 0, layer+1.
  - No capture means the indices hold, so storage output and tags stay stable under backpressure.
- Throughput and latency:
  - One row per cycle with row_ready held high.
  - Start sampled at edge 0, first row_valid after edge 2.
  - Total beats = effective layer count * size.
- FLUSH:
  - No new reads issued.
  - On row_valid && row_ready: row_valid cleared, done pulses for one cycle, state to IDLE.
- load_ready is low in STREAM and FLUSH; the loader holds its request until IDLE.
- start while busy is ignored.
- abort (any state, priority over start):
  - Next edge: state IDLE, row_valid cleared, storage_is_read low, indices zeroed.
  - No done pulse.
- A handshake in the same cycle as abort still counts downstream; the scheduler does not track it.
- row_data and tags are held while row_valid && !row_ready; valid/ready rules obeyed (no valid drop without handshake, except on abort or reset).
- Reset mid-stream behaves like abort, plus config_error is cleared.

Decomposition:
- Package matrix_scheduler_pkg: state enum (IDLE, STREAM, FLUSH) and the index-wrap helper.
- Sub-module row_output_register: one-entry valid/ready holding register. Carries row_data plus tags and flags; exposes capture_enable = !valid || ready.

Test Plan:
- Load: size=3, data_size=16; load layer 1, row 2 = 0x0001_0002_0003; stream layer_count=2 -> beat 6 has row_layer=1, row_row=2, row_data=0x000100020003, row_last=1, row_final=1.
- Back-to-back: layer_count=2, row_ready=1 -> 6 consecutive beats, first after edge 2, done one cycle after beat 6, busy low after that.
- Backpressure: row_ready toggling 1,0,0,1 -> beats are never skipped or duplicated, and data is stable while stalled.
- Clamp: layer_count=7 -> 15 beats, config_error=1. layer_count=0 -> done next cycle, 0 beats.
- Arbitration: load_valid during STREAM -> load_ready=0, no storage write. The write occurs in the first IDLE cycle. An out-of-range row index of 3 is dropped and sets config_error.
- Abort after beat 4 with row_ready=0 -> row_valid low next cycle, no done, IDLE. A new start then restarts from layer 0, row 0.
